// File: rtl/uart_rx.sv
// UART receive stage: 16x oversampled deframer for 8-bit characters with optional
// parity, feeding a show-ahead FIFO and sticky error flags for the CPU interface.
module uart_rx #(
    parameter int unsigned DIV_9600   = 326,
    parameter int unsigned DIV_19200  = 163,
    parameter int unsigned DIV_57600  = 54,
    parameter int unsigned DIV_115200 = 27,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       CLK50MHZ,
    input  logic       RST,
    input  logic       RXD,
    input  logic [7:0] DATA_CR,
    input  logic       RD_POP,
    input  logic       CLR_ERR,
    output logic [7:0] DATA_Rx,
    output logic       Rx_RDY,
    output logic       PE_Fg,
    output logic       FE_Fg,
    output logic       OE_Fg
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_n;

    logic soft_rst;
    logic unused_cr;
    assign soft_rst  = DATA_CR[7];
    assign unused_cr = ^{DATA_CR[6:5], DATA_CR[2]};

    logic        rx_meta, rxs;
    logic [1:0]  baud_l;
    logic        par_en_l, par_odd_l;
    logic [15:0] tick_cnt, div;
    logic        tick;
    logic [3:0]  s_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        par_bit;
    logic        wait_high;
    logic        start_det, bit_smp, par_smp, deliver;
    logic        pe_now, fe_now;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop, overrun;

    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else if (soft_rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RXD;
            rxs     <= rx_meta;
        end
    end

    always_comb begin
        case (baud_l)
            2'b00:   div = 16'(DIV_9600);
            2'b01:   div = 16'(DIV_19200);
            2'b10:   div = 16'(DIV_57600);
            default: div = 16'(DIV_115200);
        endcase
    end

    assign tick = (state != IDLE) && (tick_cnt == div - 16'd1);

    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST)           state <= IDLE;
        else if (soft_rst) state <= IDLE;
        else               state <= state_n;
    end

    always_comb begin
        state_n   = state;
        start_det = 1'b0;
        bit_smp   = 1'b0;
        par_smp   = 1'b0;
        deliver   = 1'b0;
        case (state)
            IDLE: if (!rxs && !wait_high) begin
                start_det = 1'b1;
                state_n   = START;
            end
            START: if (tick && s_cnt == 4'd7) state_n = rxs ? IDLE : DATA;
            DATA: if (tick && s_cnt == 4'd15) begin
                bit_smp = 1'b1;
                if (bit_cnt == 3'd7) state_n = par_en_l ? PARITY : STOP;
            end
            PARITY: if (tick && s_cnt == 4'd15) begin
                par_smp = 1'b1;
                state_n = STOP;
            end
            STOP: if (tick && s_cnt == 4'd15) begin
                deliver = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // After a low stop bit, start detection stays disarmed until the line returns high.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            tick_cnt <= '0; baud_l <= '0; par_en_l <= 1'b0; par_odd_l <= 1'b0;
            s_cnt <= '0; bit_cnt <= '0; shreg <= '0; par_bit <= 1'b0; wait_high <= 1'b0;
        end else if (soft_rst) begin
            tick_cnt <= '0; baud_l <= '0; par_en_l <= 1'b0; par_odd_l <= 1'b0;
            s_cnt <= '0; bit_cnt <= '0; shreg <= '0; par_bit <= 1'b0; wait_high <= 1'b0;
        end else begin
            if (state == IDLE || tick) tick_cnt <= '0;
            else                       tick_cnt <= tick_cnt + 16'd1;
            if (start_det) begin
                baud_l    <= DATA_CR[1:0];
                par_en_l  <= DATA_CR[4];
                par_odd_l <= DATA_CR[3];
                s_cnt     <= '0;
                bit_cnt   <= '0;
            end else if (tick) begin
                s_cnt <= (state == START && s_cnt == 4'd7) ? 4'd0 : s_cnt + 4'd1;
            end
            if (bit_smp) begin
                shreg   <= {rxs, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (par_smp) par_bit <= rxs;
            if (deliver && !rxs) wait_high <= 1'b1;
            else if (rxs)        wait_high <= 1'b0;
        end
    end

    assign pe_now  = par_en_l && ((^shreg ^ par_bit) != par_odd_l);
    assign fe_now  = !rxs;
    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign pop     = RD_POP && !empty;
    assign push    = deliver && (!full || RD_POP);
    assign overrun = deliver && full && !RD_POP;

    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0; rd_ptr <= '0; count <= '0;
        end else if (soft_rst) begin
            wr_ptr <= '0; rd_ptr <= '0; count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK50MHZ) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    assign DATA_Rx = empty ? '0 : mem[rd_ptr];
    assign Rx_RDY  = !empty;

    // A set in the same cycle as CLR_ERR takes priority.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            PE_Fg <= 1'b0; FE_Fg <= 1'b0; OE_Fg <= 1'b0;
        end else if (soft_rst) begin
            PE_Fg <= 1'b0; FE_Fg <= 1'b0; OE_Fg <= 1'b0;
        end else begin
            if (push && pe_now)   PE_Fg <= 1'b1;
            else if (CLR_ERR)     PE_Fg <= 1'b0;
            if (push && fe_now)   FE_Fg <= 1'b1;
            else if (CLR_ERR)     FE_Fg <= 1'b0;
            if (overrun)          OE_Fg <= 1'b1;
            else if (CLR_ERR)     OE_Fg <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, directed corner cases and random
// frames checked against a queue-based receiver model.
module tb_uart_rx;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned D0 = 9, D1 = 6, D2 = 4, D3 = 27;

    logic       clk = 1'b0;
    logic       rst, rxd, rd_pop, clr_err;
    logic [7:0] cr;
    logic [7:0] data_rx;
    logic       rx_rdy, pe_fg, fe_fg, oe_fg;

    always #10 clk = ~clk;

    uart_rx #(
        .DIV_9600(D0), .DIV_19200(D1), .DIV_57600(D2), .DIV_115200(D3), .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK50MHZ(clk), .RST(rst), .RXD(rxd), .DATA_CR(cr), .RD_POP(rd_pop),
        .CLR_ERR(clr_err), .DATA_Rx(data_rx), .Rx_RDY(rx_rdy),
        .PE_Fg(pe_fg), .FE_Fg(fe_fg), .OE_Fg(oe_fg)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mq[$];
    bit m_pe, m_fe, m_oe;

    typedef struct {
        logic [7:0] d;
        logic [1:0] sel;
        bit par_on, odd, pbit, stop;
        bit exp_pe, exp_fe;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int bitclk(input logic [1:0] sel);
        case (sel)
            2'b00:   return 16 * D0;
            2'b01:   return 16 * D1;
            2'b10:   return 16 * D2;
            default: return 16 * D3;
        endcase
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] sel,
                              input bit par_on, input bit pbit, input bit stop);
        int bc;
        bc = bitclk(sel);
        rxd = 1'b0;
        wait_clk(bc);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_clk(bc);
        end
        if (par_on) begin
            rxd = pbit;
            wait_clk(bc);
        end
        rxd = stop;
        wait_clk(bc);
        rxd = 1'b1;
    endtask

    function automatic bit parity_bad(input logic [7:0] d, input bit pbit, input bit odd);
        int n;
        n = $countones(d) + int'(pbit);
        return odd ? (n % 2 == 0) : (n % 2 == 1);
    endfunction

    task automatic model_frame(input logic [7:0] d, input bit par_on, input bit odd,
                               input bit pbit, input bit stop);
        if (mq.size() < DEPTH) begin
            mq.push_back(d);
            if (par_on && parity_bad(d, pbit, odd)) m_pe = 1'b1;
            if (!stop) m_fe = 1'b1;
        end else begin
            m_oe = 1'b1;
        end
    endtask

    task automatic check_model(input string tag);
        check($sformatf("%s.rdy", tag), 32'(rx_rdy), 32'(mq.size() != 0));
        check($sformatf("%s.data", tag), 32'(data_rx), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        check($sformatf("%s.pe", tag), 32'(pe_fg), 32'(m_pe));
        check($sformatf("%s.fe", tag), 32'(fe_fg), 32'(m_fe));
        check($sformatf("%s.oe", tag), 32'(oe_fg), 32'(m_oe));
    endtask

    task automatic do_pop();
        rd_pop = 1'b1;
        wait_clk(1);
        rd_pop = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic do_clr();
        clr_err = 1'b1;
        wait_clk(1);
        clr_err = 1'b0;
        m_pe = 1'b0; m_fe = 1'b0; m_oe = 1'b0;
    endtask

    initial begin
        #10_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit prev_bad;
        tbl[0] = '{8'hA5, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h03, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{8'h03, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h5A, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8'h00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{8'hFF, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{8'h80, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{8'h7E, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{8'h96, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; rxd = 1'b1; cr = 8'h00; rd_pop = 1'b0; clr_err = 1'b0;
        m_pe = 1'b0; m_fe = 1'b0; m_oe = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);
        check_model("reset");

        // 115200 baud latency and basic receive
        cr = 8'h03;
        wait_clk(1);
        lat = 0;
        fork
            send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b1);
            begin
                while (!rx_rdy && lat < 6000) begin
                    wait_clk(1);
                    lat++;
                end
            end
        join
        n_checks++;
        if (lat < 4102 || lat > 4110) begin
            n_errors++;
            $display("FAIL t1.latency: got %0d cycles expected 4102..4110", lat);
        end
        model_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        check_model("t1");
        do_pop();
        check_model("t1.pop");

        // vector table
        for (int i = 0; i < 10; i++) begin
            cr = {3'b000, tbl[i].par_on, tbl[i].odd, 1'b0, tbl[i].sel};
            wait_clk(2);
            send_frame(tbl[i].d, tbl[i].sel, tbl[i].par_on, tbl[i].pbit, tbl[i].stop);
            wait_clk(2);
            check($sformatf("tbl%0d.rdy", i), 32'(rx_rdy), 32'd1);
            check($sformatf("tbl%0d.data", i), 32'(data_rx), 32'(tbl[i].d));
            check($sformatf("tbl%0d.pe", i), 32'(pe_fg), 32'(tbl[i].exp_pe));
            check($sformatf("tbl%0d.fe", i), 32'(fe_fg), 32'(tbl[i].exp_fe));
            check($sformatf("tbl%0d.oe", i), 32'(oe_fg), 32'd0);
            do_pop();
            check($sformatf("tbl%0d.pop_rdy", i), 32'(rx_rdy), 32'd0);
            check($sformatf("tbl%0d.pop_data", i), 32'(data_rx), 32'd0);
            do_clr();
            check($sformatf("tbl%0d.clr_pe", i), 32'(pe_fg), 32'd0);
            check($sformatf("tbl%0d.clr_fe", i), 32'(fe_fg), 32'd0);
        end

        // break: line held low for three frame times
        cr = 8'h02;
        wait_clk(2);
        rxd = 1'b0;
        wait_clk(3 * 10 * bitclk(2'b10));
        rxd = 1'b1;
        wait_clk(70);
        model_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check_model("brk");
        do_pop();
        check_model("brk.pop");
        do_clr();

        // overrun, then pop coinciding with the stop sample of the fifth frame
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k * 17), 2'b10, 1'b0, 1'b0, 1'b1);
            model_frame(8'(k * 17), 1'b0, 1'b0, 1'b0, 1'b1);
        end
        wait_clk(3);
        check_model("ovr");
        for (int k = 0; k < 4; k++) begin
            do_pop();
            check_model($sformatf("ovr.pop%0d", k));
        end
        do_clr();
        for (int k = 1; k <= 4; k++) begin
            send_frame(8'(k * 17), 2'b10, 1'b0, 1'b0, 1'b1);
            model_frame(8'(k * 17), 1'b0, 1'b0, 1'b0, 1'b1);
        end
        wait_clk(5);
        fork
            send_frame(8'h55, 2'b10, 1'b0, 1'b0, 1'b1);
            begin
                wait_clk(2 + 152 * D2);
                rd_pop = 1'b1;
                wait_clk(1);
                rd_pop = 1'b0;
            end
        join
        void'(mq.pop_front());
        model_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_clk(2);
        check_model("ovr2");
        for (int k = 0; k < 4; k++) begin
            do_pop();
            check_model($sformatf("ovr2.pop%0d", k));
        end

        // false start glitch, then back-to-back frames
        rxd = 1'b0;
        wait_clk(4 * D2);
        rxd = 1'b1;
        wait_clk(11 * bitclk(2'b10));
        check_model("glitch");
        send_frame(8'h01, 2'b10, 1'b0, 1'b0, 1'b1);
        send_frame(8'h80, 2'b10, 1'b0, 1'b0, 1'b1);
        model_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        model_frame(8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_clk(2);
        check_model("b2b");
        do_pop();
        check_model("b2b.pop1");
        do_pop();
        check_model("b2b.pop2");

        // hard reset mid-data with queued characters and a flag set
        send_frame(8'h12, 2'b10, 1'b0, 1'b0, 1'b0);
        wait_clk(4);
        send_frame(8'h34, 2'b10, 1'b0, 1'b0, 1'b1);
        model_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
        model_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1);
        check_model("prerst");
        rxd = 1'b0;
        wait_clk(bitclk(2'b10));
        rxd = 1'b1;
        wait_clk(3 * bitclk(2'b10));
        rst = 1'b1;
        mq.delete(); m_pe = 1'b0; m_fe = 1'b0; m_oe = 1'b0;
        wait_clk(2);
        check_model("rst.active");
        rst = 1'b0;
        wait_clk(8 * bitclk(2'b10));
        check_model("rst.after");
        send_frame(8'hC3, 2'b10, 1'b0, 1'b0, 1'b1);
        model_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
        check_model("rst.c3");
        do_pop();

        // soft reset mid-frame with two characters queued
        cr = 8'h12;
        wait_clk(2);
        send_frame(8'h03, 2'b10, 1'b1, 1'b1, 1'b1);
        send_frame(8'h44, 2'b10, 1'b1, 1'b0, 1'b1);
        model_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1);
        model_frame(8'h44, 1'b1, 1'b0, 1'b0, 1'b1);
        check_model("presoft");
        rxd = 1'b0;
        wait_clk(3 * bitclk(2'b10));
        rxd = 1'b1;
        cr = 8'h92;
        wait_clk(2);
        cr = 8'h02;
        mq.delete(); m_pe = 1'b0; m_fe = 1'b0; m_oe = 1'b0;
        check_model("soft");
        wait_clk(9 * bitclk(2'b10));
        check_model("soft.after");
        send_frame(8'hC3, 2'b10, 1'b0, 1'b0, 1'b1);
        model_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
        check_model("soft.c3");
        do_pop();

        // random frames with mid-frame configuration changes
        prev_bad = 1'b0;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic [1:0] sel;
            bit par_on, odd, pbit, stop;
            int gap, npop;
            d      = 8'($urandom);
            sel    = 2'($urandom_range(0, 2));
            par_on = 1'($urandom);
            odd    = 1'($urandom);
            pbit   = odd ? ($countones(d) % 2 == 0) : ($countones(d) % 2 == 1);
            if ($urandom_range(0, 3) == 0) pbit = ~pbit;
            stop   = ($urandom_range(0, 7) != 0);
            cr = {3'b000, par_on, odd, 1'b0, sel};
            gap = prev_bad ? $urandom_range(4, 20) : $urandom_range(1, 20);
            wait_clk(gap);
            fork
                send_frame(d, sel, par_on, pbit, stop);
                begin
                    wait_clk($urandom_range(20, 4 * bitclk(sel)));
                    cr = 8'($urandom) & 8'h7F;
                end
            join
            model_frame(d, par_on, odd, pbit, stop);
            prev_bad = !stop;
            wait_clk(1);
            check_model($sformatf("rnd%0d", n));
            npop = $urandom_range(0, 2);
            for (int p = 0; p < npop; p++) begin
                do_pop();
                check_model($sformatf("rnd%0d.pop", n));
            end
            if ($urandom_range(0, 3) == 0) begin
                do_clr();
                check_model($sformatf("rnd%0d.clr", n));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive stage of the UART. Directly upstream of the CPU interface.
- Oversamples the RXD line at 16x the selected baud rate and deframes 8-bit characters, with optional parity.
- Buffers received characters in a small show-ahead FIFO.
- Produces DATA_Rx, Rx_RDY, PE_Fg, FE_Fg and OE_Fg for the CPU interface. Configuration comes from that block's DATA_CR output.

Parameters:
- DIV_9600, 326, clocks per 16x tick at 9600 baud (50 MHz / (16*9600), rounded).
- DIV_19200, 163, clocks per tick at 19200 baud.
- DIV_57600, 54, clocks per tick at 57600 baud.
- DIV_115200, 27, clocks per tick at 115200 baud.
- FIFO_DEPTH, 4, number of receive FIFO entries; must be a power of 2, minimum 2.

Ports:
- CLK50MHZ  input  1  system clock, 50 MHz.
- RST  input  1  asynchronous, active-high reset.
- RXD  input  1  serial receive line; asynchronous; idles high.
- DATA_CR  input  8  configuration register:
  - [7] soft reset
  - [4] parity enable
  - [3] 1 = odd parity, 0 = even parity
  - [1:0] baud select: 00=9600, 01=19200, 10=57600, 11=115200
  - other bits ignored
- RD_POP  input  1  one-cycle pulse; removes the FIFO head character (CPU data read).
- CLR_ERR  input  1  one-cycle pulse; clears the sticky error flags.
- DATA_Rx  output  8  FIFO head character; 0 when the FIFO is empty.
- Rx_RDY  output  1  1 when the FIFO holds at least one character.
- PE_Fg  output  1  sticky parity error flag.
- FE_Fg  output  1  sticky framing error flag.
- OE_Fg  output  1  sticky overrun error flag.

Behaviour:
- Reset and soft reset:
  - RST is asynchronous and active-high. DATA_CR[7]=1 is a synchronous reset with identical effect.
  - Either one: FSM goes to IDLE, counters cleared, FIFO emptied.
  - Outputs after reset: DATA_Rx=0, Rx_RDY=0, PE_Fg=0, FE_Fg=0, OE_Fg=0.
  - Synchronizer flops reset to 1.
  - A reset mid-frame discards the partial character.
- Input synchronizer: RXD passes through a 2-flop synchronizer. All decisions use the synchronized value (rxs).
- Tick generator:
  - A counter produces a one-cycle tick every DIV clocks.
  - DIV is chosen by the baud select latched at start detection. Changing DATA_CR[1:0] mid-frame has no effect until the next frame.
  - The counter restarts on start detection.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when rxs=0, latch baud select, parity enable and parity sense; clear the tick and sample counters; go to START.
  - START: at the 8th tick (mid start bit), sample rxs. If rxs=1 it is a false start: return to IDLE, nothing stored. If rxs=0, go to DATA.
  - DATA: every 16th tick, sample one bit into the shift register, LSB first. After 8 bits, go to PARITY if parity is enabled, else STOP.
  - PARITY: at the 16th tick, sample the parity bit. The check passes when XOR(data, parity bit) = 1 for odd parity, or 0 for even parity. Then go to STOP.
  - STOP: at the 16th tick (mid stop bit), sample rxs. rxs=0 is a framing error. The character is delivered (see below) and the FSM returns to IDLE in the same cycle, so a start bit that follows immediately is accepted.
- Character delivery (at the stop-bit sample cycle):
  - FIFO not full: push the character. Set PE_Fg on a parity error and FE_Fg on a framing error. Errored characters are still stored.
  - FIFO full and RD_POP not asserted: drop the character and set OE_Fg. PE/FE are not updated for a dropped character.
  - FIFO full and RD_POP asserted in the same cycle: pop and push both occur, with no overrun.
- FIFO:
  - Show-ahead: DATA_Rx always equals the head entry.
  - Push latency: the character is visible and Rx_RDY=1 the cycle after the stop-bit sample.
  - RD_POP when empty is ignored; pointers do not move.
  - Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an occupancy count of log2(FIFO_DEPTH)+1 bits.
- Error flags:
  - Sticky until CLR_ERR, RST or soft reset.
  - If CLR_ERR and a new error occur in the same cycle, the set wins.
- Framing with a break (RXD held low): a frame of 0x00 with FE is stored. The FSM then waits in IDLE for rxs=1 before arming start detection again, so a sustained low produces exactly one character.

Test Plan:
1. 115200 baud (432 clocks/bit), no parity; send 0xA5 with a good stop bit -> Rx_RDY=1 and DATA_Rx=0xA5 about 9.5 bit times (±2 clocks plus sync delay) after the start edge; all flags 0. Pulse RD_POP -> Rx_RDY=0, DATA_Rx=0.
2. Even parity, send 0x03 with parity bit 1 -> character stored, PE_Fg=1. Pulse CLR_ERR -> PE_Fg=0. Odd parity, send 0x03 with parity bit 1 -> PE_Fg stays 0.
3. Send 0x5A with the stop bit forced low -> DATA_Rx=0x5A, FE_Fg=1. Hold RXD low for 3 frames -> exactly one 0x00 entry, FE_Fg=1.
4. FIFO_DEPTH=4: send 5 characters 0x11..0x55 with no pops -> OE_Fg=1, FIFO holds 0x11..0x44. Pop in order -> 0x11,0x22,0x33,0x44, then Rx_RDY=0. Repeat with RD_POP asserted on the 5th stop-sample cycle -> OE_Fg=0 and 0x55 is stored.
5. Send a 4-tick low glitch on RXD -> false start, no character, FSM in IDLE. Then send back-to-back frames 0x01,0x80 with no idle gap -> both received correctly.
6. Assert RST mid-DATA, and separately DATA_CR[7]=1 mid-frame with 2 characters queued -> all outputs 0 and FIFO empty. The next clean frame 0xC3 is received correctly.
